// File: rtl/dyn_vc_allocator.sv
// dyn_vc_allocator: registered separable (input-first) VC allocator.
// Stage 1: every valid input VC picks the lowest-index free output VC at
// its routed port. Stage 2: every output VC picks one of the input VCs that
// chose it. The highest priority wins, and round-robin breaks ties within
// that priority. The block also tracks output-VC occupancy.
module dyn_vc_allocator #(
    parameter int num_ports      = 5,
    parameter int num_vcs        = 4,
    parameter int num_priorities = 2,
    parameter int vc_idx_width   = $clog2(num_vcs),
    parameter int pri_width      = (num_priorities > 1) ? $clog2(num_priorities) : 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [num_ports-1:0]                    active_ip_i,
    input  logic [num_ports-1:0]                    active_op_i,
    input  logic [num_ports*num_vcs-1:0]            req_ip_ivc_i,
    input  logic [num_ports*num_vcs*pri_width-1:0]  pri_ip_ivc_i,
    input  logic [num_ports*num_vcs*num_ports-1:0]  route_ip_ivc_op_i,
    input  logic [num_ports*num_vcs-1:0]            elig_op_ovc_i,
    input  logic [num_ports*num_vcs-1:0]            release_op_ovc_i,
    output logic [num_ports*num_vcs-1:0]            gnt_ip_ivc_o,
    output logic [num_ports*num_vcs*vc_idx_width-1:0] gnt_ovc_ip_ivc_o,
    output logic [num_ports*num_vcs-1:0]            gnt_op_ovc_o,
    output logic [num_ports*num_vcs-1:0]            busy_op_ovc_o
);

    // Flat VC index space: input VC (ip, ivc) -> ip*num_vcs+ivc.
    // Output VC (op, ovc) -> op*num_vcs+ovc.
    localparam int n_vc_total = num_ports * num_vcs;
    localparam int idx_width  = $clog2(n_vc_total);

    logic [n_vc_total-1:0]              free_ovc;
    logic [n_vc_total-1:0]              sel_vld;
    logic [idx_width-1:0]               sel_oidx [n_vc_total];

    logic [n_vc_total-1:0]              gnt_ip_ivc_q, gnt_ip_ivc_d;
    logic [n_vc_total*vc_idx_width-1:0] gnt_ovc_q, gnt_ovc_d;
    logic [n_vc_total-1:0]              gnt_op_ovc_q, gnt_op_ovc_d;
    logic [n_vc_total-1:0]              busy_q, busy_d;
    logic [idx_width-1:0]               rr_ptr_q [n_vc_total];
    logic [idx_width-1:0]               rr_ptr_d [n_vc_total];

    // An output VC is free when it is eligible, unoccupied and its port is enabled.
    always_comb begin
        for (int o = 0; o < n_vc_total; o++) begin
            free_ovc[o] = elig_op_ovc_i[o] & ~busy_q[o] & active_op_i[o / num_vcs];
        end
    end

    // Stage 1: each valid input VC selects the lowest-index free output VC at its routed port.
    always_comb begin
        logic [num_ports-1:0] route;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        sel_vld = '0;
        route   = '0;
        for (int i = 0; i < n_vc_total; i++) begin
            sel_oidx[i] = '0;
            route       = route_ip_ivc_op_i[i*num_ports +: num_ports];
            // Last cycle's winner sits out one cycle. Malformed routes are ignored.
            if (req_ip_ivc_i[i] && active_ip_i[i / num_vcs] &&
                !gnt_ip_ivc_q[i] && $onehot(route)) begin
                for (int op = 0; op < num_ports; op++) begin
                    if (route[op]) begin
                        // Descending scan: the last hit is the lowest free index.
                        for (int v = num_vcs - 1; v >= 0; v--) begin
                            if (free_ovc[op*num_vcs + v]) begin
                                sel_vld[i]  = 1'b1;
                                sel_oidx[i] = idx_width'(op*num_vcs + v);
                            end
                        end
                    end
                end
            end
        end
    end

    // Stage 2: per output VC, pick the top priority, then round-robin from its pointer. Also form next state.
    always_comb begin
        logic [pri_width-1:0] top_pri;
        logic                 found;
        int                   win;
        int                   idx;
        gnt_ip_ivc_d = '0;
        gnt_ovc_d    = '0;
        gnt_op_ovc_d = '0;
        rr_ptr_d     = rr_ptr_q;
        top_pri      = '0;
        found        = 1'b0;
        win          = 0;
        idx          = 0;
        for (int o = 0; o < n_vc_total; o++) begin
            top_pri = '0;
            for (int i = 0; i < n_vc_total; i++) begin
                if (sel_vld[i] && (sel_oidx[i] == idx_width'(o)) &&
                    (pri_ip_ivc_i[i*pri_width +: pri_width] > top_pri)) begin
                    top_pri = pri_ip_ivc_i[i*pri_width +: pri_width];
                end
            end
            found = 1'b0;
            win   = 0;
            for (int k = 0; k < n_vc_total; k++) begin
                idx = int'(rr_ptr_q[o]) + k;
                if (idx >= n_vc_total) begin
                    idx = idx - n_vc_total;
                end
                if (!found && sel_vld[idx] && (sel_oidx[idx] == idx_width'(o)) &&
                    (pri_ip_ivc_i[idx*pri_width +: pri_width] == top_pri)) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            if (found) begin
                gnt_ip_ivc_d[win]                             = 1'b1;
                gnt_ovc_d[win*vc_idx_width +: vc_idx_width]   = vc_idx_width'(o % num_vcs);
                gnt_op_ovc_d[o]                               = 1'b1;
                rr_ptr_d[o] = (win == n_vc_total - 1) ? '0 : idx_width'(win + 1);
            end
        end
        // A busy VC cannot be granted, so a grant and a release never hit the same VC.
        busy_d = (busy_q & ~release_op_ovc_i) | gnt_op_ovc_d;
    end

    // Registered grants, occupancy and round-robin pointers. Reset is synchronous.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            gnt_ip_ivc_q <= '0;
            gnt_ovc_q    <= '0;
            gnt_op_ovc_q <= '0;
            busy_q       <= '0;
            // NOTE: the pointer array is reset explicitly because the fairness order must start at index 0.
            for (int o = 0; o < n_vc_total; o++) begin
                rr_ptr_q[o] <= '0;
            end
        end else begin
            gnt_ip_ivc_q <= gnt_ip_ivc_d;
            gnt_ovc_q    <= gnt_ovc_d;
            gnt_op_ovc_q <= gnt_op_ovc_d;
            busy_q       <= busy_d;
            for (int o = 0; o < n_vc_total; o++) begin
                rr_ptr_q[o] <= rr_ptr_d[o];
            end
        end
    end

    assign gnt_ip_ivc_o     = gnt_ip_ivc_q;
    assign gnt_ovc_ip_ivc_o = gnt_ovc_q;
    assign gnt_op_ovc_o     = gnt_op_ovc_q;
    assign busy_op_ovc_o    = busy_q;

endmodule

// File: tb/tb_dyn_vc_allocator.sv
// Testbench for dyn_vc_allocator: directed scenarios plus randomized traffic
// checked against a behavioural allocation model.
module tb_dyn_vc_allocator;

    localparam int P  = 5;
    localparam int V  = 4;
    localparam int NP = 2;
    localparam int N  = P * V;
    localparam int VW = 2;
    localparam int PW = 1;

    logic               clk;
    logic               reset;
    logic [P-1:0]       active_ip, active_op;
    logic [N-1:0]       req, elig, rel;
    logic [N*PW-1:0]    pri;
    logic [N*P-1:0]     route;
    logic [N-1:0]       gnt_ip, gnt_op, busy;
    logic [N*VW-1:0]    gnt_ovc;

    int checks   = 0;
    int failures = 0;

    // Model state: registered outputs plus one fairness pointer per output VC.
    bit m_busy[N], m_gnt_ip[N], m_gnt_op[N];
    int m_gnt_ovc[N], m_ptr[N];
    bit n_busy[N], n_gnt_ip[N], n_gnt_op[N];
    int n_gnt_ovc[N], n_ptr[N];

    logic [N-1:0]    exp_gnt_ip, exp_gnt_op, exp_busy;
    logic [N*VW-1:0] exp_gnt_ovc;

    dyn_vc_allocator #(
        .num_ports(P), .num_vcs(V), .num_priorities(NP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .active_ip_i       (active_ip),
        .active_op_i       (active_op),
        .req_ip_ivc_i      (req),
        .pri_ip_ivc_i      (pri),
        .route_ip_ivc_op_i (route),
        .elig_op_ovc_i     (elig),
        .release_op_ovc_i  (rel),
        .gnt_ip_ivc_o      (gnt_ip),
        .gnt_ovc_ip_ivc_o  (gnt_ovc),
        .gnt_op_ovc_o      (gnt_op),
        .busy_op_ovc_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] bitv(input int k);
        logic [N-1:0] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    // One allocation round, computed from the current inputs and model state.
    task automatic model_eval();
        int choice[N];
        logic [P-1:0] r;
        int port, best, bpri, bdist, p, d;
        for (int o = 0; o < N; o++) begin
            n_gnt_ip[o]  = 0;
            n_gnt_op[o]  = 0;
            n_gnt_ovc[o] = 0;
            n_busy[o]    = 0;
            n_ptr[o]     = reset ? m_ptr[o] : 0;
        end
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                choice[i] = -1;
                r = route[i*P +: P];
                if (req[i] && active_ip[i / V] && !m_gnt_ip[i] && $countones(r) == 1) begin
                    port = 0;
                    for (int b = 0; b < P; b++) if (r[b]) port = b;
                    for (int v = 0; v < V; v++)
                        if (choice[i] < 0 && elig[port*V+v] && !m_busy[port*V+v] && active_op[port])
                            choice[i] = port*V + v;
                end
            end
            for (int o = 0; o < N; o++) begin
                best = -1; bpri = 0; bdist = 0;
                for (int i = 0; i < N; i++) begin
                    if (choice[i] == o) begin
                        p = int'(pri[i*PW +: PW]);
                        d = (i - m_ptr[o] + N) % N;
                        if (best < 0 || p > bpri || (p == bpri && d < bdist)) begin
                            best = i; bpri = p; bdist = d;
                        end
                    end
                end
                if (best >= 0) begin
                    n_gnt_ip[best]  = 1;
                    n_gnt_ovc[best] = o % V;
                    n_gnt_op[o]     = 1;
                    n_ptr[o]        = (best + 1) % N;
                end
            end
            for (int o = 0; o < N; o++)
                n_busy[o] = (m_busy[o] && !rel[o]) || n_gnt_op[o];
        end
    endtask

    // Advance one clock: evaluate the model, take the edge, then settle past it.
    task automatic step();
        model_eval();
        @(posedge clk);
        m_busy = n_busy; m_gnt_ip = n_gnt_ip; m_gnt_op = n_gnt_op;
        m_gnt_ovc = n_gnt_ovc; m_ptr = n_ptr;
        #1;
        for (int i = 0; i < N; i++) begin
            exp_gnt_ip[i] = m_gnt_ip[i];
            exp_gnt_op[i] = m_gnt_op[i];
            exp_busy[i]   = m_busy[i];
            exp_gnt_ovc[i*VW +: VW] = VW'(m_gnt_ovc[i]);
        end
    endtask

    task automatic idle_inputs();
        active_ip = '1; active_op = '1; elig = '1;
        req = '0; rel = '0; pri = '0; route = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({gnt_ip, gnt_ovc, gnt_op, busy} !== '0) begin
                failures++;
                $display("FAIL reset_hold: got ip=%h ovc=%h op=%h busy=%h, want all 0", gnt_ip, gnt_ovc, gnt_op, busy);
            end
        end
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if ({gnt_ip, gnt_ovc, gnt_op, busy} !== '0) begin
                failures++;
                $display("FAIL idle cycle %0d: got ip=%h ovc=%h op=%h busy=%h, want all 0", c, gnt_ip, gnt_ovc, gnt_op, busy);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req = bitv(6);
        route[6*P + 3] = 1'b1;
        step();
        checks++;
        if (gnt_ip !== bitv(6) || gnt_ovc !== '0 || gnt_op !== bitv(12) || busy !== bitv(12)) begin
            failures++;
            $display("FAIL single_first: got ip=%h ovc=%h op=%h busy=%h, want ip=%h ovc=0 op=%h busy=%h",
                     gnt_ip, gnt_ovc, gnt_op, busy, bitv(6), bitv(12), bitv(12));
        end
        req = '0;
        step();
        checks++;
        if (gnt_ip !== '0 || busy !== bitv(12)) begin
            failures++;
            $display("FAIL single_gap: got ip=%h busy=%h, want ip=0 busy=%h", gnt_ip, busy, bitv(12));
        end
        req = bitv(6);
        step();
        checks++;
        if (gnt_ip !== bitv(6) || gnt_ovc[6*VW +: VW] !== 2'd1 || gnt_op !== bitv(13) ||
            busy !== (bitv(12) | bitv(13))) begin
            failures++;
            $display("FAIL single_second: got ip=%h ovc6=%0d op=%h busy=%h, want ip=%h ovc6=1 op=%h busy=%h",
                     gnt_ip, gnt_ovc[6*VW +: VW], gnt_op, busy, bitv(6), bitv(13), bitv(12) | bitv(13));
        end
    endtask

    // Two requesters compete for port4/ovc0. Each grant is followed by a release pulse.
    task automatic rr_rounds(input int rounds, input bit high_first, input string tag);
        logic [N-1:0] exp;
        for (int r = 0; r < rounds; r++) begin
            step();
            exp = high_first ? bitv(8) : ((r % 2 == 0) ? bitv(0) : bitv(8));
            checks++;
            if (gnt_ip !== exp || gnt_op !== bitv(16)) begin
                failures++;
                $display("FAIL %s round %0d: got ip=%h op=%h, want ip=%h op=%h", tag, r, gnt_ip, gnt_op, exp, bitv(16));
            end
            rel = bitv(16);
            step();
            rel = '0;
            checks++;
            if (gnt_ip !== '0 || busy !== '0) begin
                failures++;
                $display("FAIL %s release %0d: got ip=%h busy=%h, want 0/0", tag, r, gnt_ip, busy);
            end
        end
    endtask

    task automatic test_rr();
        do_reset();
        elig = bitv(16);
        req  = bitv(0) | bitv(8);
        route[0*P + 4] = 1'b1;
        route[8*P + 4] = 1'b1;
        rr_rounds(4, 1'b0, "rr");
    endtask

    task automatic test_priority();
        do_reset();
        elig = bitv(16);
        req  = bitv(0) | bitv(8);
        route[0*P + 4] = 1'b1;
        route[8*P + 4] = 1'b1;
        pri[8*PW +: PW] = 1'b1;
        rr_rounds(3, 1'b1, "prio");
        req = bitv(0);
        step();
        checks++;
        if (gnt_ip !== bitv(0)) begin
            failures++;
            $display("FAIL prio_low_after_drop: got ip=%h, want %h", gnt_ip, bitv(0));
        end
    endtask

    task automatic test_exhaust();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            route = '0;
            route[(4+k)*P + 0] = 1'b1;
            req = bitv(4 + k);
            step();
            checks++;
            if (gnt_ip !== bitv(4 + k) || int'(gnt_ovc[(4+k)*VW +: VW]) != k || gnt_op !== bitv(k)) begin
                failures++;
                $display("FAIL exhaust_fill %0d: got ip=%h ovc=%0d op=%h, want ip=%h ovc=%0d op=%h",
                         k, gnt_ip, gnt_ovc[(4+k)*VW +: VW], gnt_op, bitv(4 + k), k, bitv(k));
            end
        end
        route = '0;
        route[12*P + 0] = 1'b1;
        req = bitv(12);
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (gnt_ip !== '0 || busy !== N'(20'h0000F)) begin
                failures++;
                $display("FAIL exhaust_full %0d: got ip=%h busy=%h, want ip=0 busy=0000f", c, gnt_ip, busy);
            end
        end
        rel = bitv(2);
        step();
        rel = '0;
        checks++;
        if (gnt_ip !== '0 || busy !== N'(20'h0000B)) begin
            failures++;
            $display("FAIL exhaust_release: got ip=%h busy=%h, want ip=0 busy=0000b", gnt_ip, busy);
        end
        step();
        checks++;
        if (gnt_ip !== bitv(12) || gnt_ovc[12*VW +: VW] !== 2'd2 || gnt_op !== bitv(2) || busy !== N'(20'h0000F)) begin
            failures++;
            $display("FAIL exhaust_regrant: got ip=%h ovc12=%0d op=%h busy=%h, want ip=%h ovc12=2 op=%h busy=0000f",
                     gnt_ip, gnt_ovc[12*VW +: VW], gnt_op, busy, bitv(12), bitv(2));
        end
    endtask

    task automatic test_gating();
        // Output port disabled: no grants. The pointer must still start at 0 afterwards.
        do_reset();
        active_op[3] = 1'b0;
        req = bitv(0) | bitv(8);
        route[0*P + 3] = 1'b1;
        route[8*P + 3] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (gnt_ip !== '0 || busy !== '0) begin
                failures++;
                $display("FAIL gate_op %0d: got ip=%h busy=%h, want 0/0", c, gnt_ip, busy);
            end
        end
        active_op = '1;
        step();
        checks++;
        if (gnt_ip !== bitv(0) || gnt_op !== bitv(12)) begin
            failures++;
            $display("FAIL gate_op_reenable: got ip=%h op=%h, want ip=%h op=%h", gnt_ip, gnt_op, bitv(0), bitv(12));
        end
        // Input port disabled.
        do_reset();
        active_ip[2] = 1'b0;
        req = bitv(8);
        route[8*P + 1] = 1'b1;
        step();
        checks++;
        if (gnt_ip !== '0 || busy !== '0) begin
            failures++;
            $display("FAIL gate_ip: got ip=%h busy=%h, want 0/0", gnt_ip, busy);
        end
        // Multi-hot and zero-hot routes.
        do_reset();
        req = bitv(1);
        route[1*P +: P] = 5'b00110;
        step();
        checks++;
        if (gnt_ip !== '0 || busy !== '0) begin
            failures++;
            $display("FAIL route_multihot: got ip=%h busy=%h, want 0/0", gnt_ip, busy);
        end
        route = '0;
        step();
        checks++;
        if (gnt_ip !== '0 || busy !== '0) begin
            failures++;
            $display("FAIL route_zerohot: got ip=%h busy=%h, want 0/0", gnt_ip, busy);
        end
        // Reset with a request pending and a VC already busy.
        route[1*P + 0] = 1'b1;
        step();
        route = '0;
        route[2*P + 0] = 1'b1;
        req = bitv(2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if ({gnt_ip, gnt_ovc, gnt_op, busy} !== '0) begin
            failures++;
            $display("FAIL reset_midop: got ip=%h ovc=%h op=%h busy=%h, want all 0", gnt_ip, gnt_ovc, gnt_op, busy);
        end
    endtask

    task automatic test_random();
        logic [P-1:0] r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 99) != 0);
            for (int p = 0; p < P; p++) begin
                active_ip[p] = ($urandom_range(0, 9) != 0);
                active_op[p] = ($urandom_range(0, 9) != 0);
            end
            req  = N'($urandom);
            elig = ~(N'($urandom) & N'($urandom) & N'($urandom));
            rel  = N'($urandom) & N'($urandom);
            pri  = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 19) == 0) begin
                    r = P'($urandom);
                end else begin
                    r = '0;
                    r[$urandom_range(0, P-1)] = 1'b1;
                end
                route[i*P +: P] = r;
            end
            step();
            checks++;
            if (gnt_ip !== exp_gnt_ip || gnt_ovc !== exp_gnt_ovc || gnt_op !== exp_gnt_op || busy !== exp_busy) begin
                failures++;
                $display("FAIL random cycle %0d: got ip=%h ovc=%h op=%h busy=%h, want ip=%h ovc=%h op=%h busy=%h",
                         c, gnt_ip, gnt_ovc, gnt_op, busy, exp_gnt_ip, exp_gnt_ovc, exp_gnt_op, exp_busy);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_rr();
        test_priority();
        test_exhaust();
        test_gating();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
